// File: rtl/ip_msx_bus_bridge.sv
// MSX cartridge slot to VDP port-bus bridge: synchronises slot strobes and issues one req/ack per CPU access.
// Optional macro MSX_BRIDGE_WAIT_EN builds the Z80 wait-stretch output; otherwise o_wait is tied low.
module ip_msx_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_n_reset,
  input  logic       i_n_ce,
  input  logic       i_n_rd,
  input  logic       i_n_wr,
  input  logic [1:0] i_a,
  input  logic [7:0] i_d_in,
  output logic [7:0] o_d_out,
  output logic       o_is_output,
  output logic       o_wait,
  output logic       o_req,
  input  logic       i_ack,
  output logic       o_wr,
  output logic [1:0] o_address,
  output logic [7:0] o_wdata,
  input  logic [7:0] i_rdata,
  output logic       o_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Strobe vectors are {n_ce, n_rd, n_wr}
  logic [2:0] r_sync_s1, r_sync_s2, r_sync_s3;
  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_req, r_wr, r_is_output, r_timeout;
  logic [1:0] r_address;
  logic [7:0] r_wdata, r_d_out;

  logic w_rd_act, w_wr_act, w_act_s2, w_act_s3, w_start;

  assign w_rd_act = !r_sync_s2[2] & !r_sync_s2[1];
  assign w_wr_act = !r_sync_s2[2] & !r_sync_s2[0];
  assign w_act_s2 = w_rd_act | w_wr_act;
  assign w_act_s3 = !r_sync_s3[2] & (!r_sync_s3[1] | !r_sync_s3[0]);
  assign w_start  = w_act_s2 & !w_act_s3;

  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      r_sync_s1   <= 3'b111;
      r_sync_s2   <= 3'b111;
      r_sync_s3   <= 3'b111;
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_address   <= 2'd0;
      r_wdata     <= 8'd0;
      r_d_out     <= 8'hFF;
      r_is_output <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_sync_s1 <= {i_n_ce, i_n_rd, i_n_wr};
      r_sync_s2 <= r_sync_s1;
      r_sync_s3 <= r_sync_s2;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            // Simultaneous read and write strobes resolve to a write
            r_address   <= i_a;
            r_wdata     <= i_d_in;
            r_wr        <= w_wr_act;
            r_is_output <= !w_wr_act;
            r_req       <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_ack) begin
            r_req   <= 1'b0;
            if (!r_wr) r_d_out <= i_rdata;
            r_state <= ST_HOLD;
          end else if (r_cnt == TO_LAST) begin
            r_req     <= 1'b0;
            r_d_out   <= 8'hFF;
            r_timeout <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          // Stay here until the CPU releases the strobe so one access yields one request
          if (!w_act_s2) begin
            r_is_output <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MSX_BRIDGE_WAIT_EN
  assign o_wait = (r_state == ST_REQ);
`else
  assign o_wait = 1'b0;
`endif

  assign o_req       = r_req;
  assign o_wr        = r_wr;
  assign o_address   = r_address;
  assign o_wdata     = r_wdata;
  assign o_d_out     = r_d_out;
  assign o_is_output = r_is_output;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_ip_msx_bus_bridge.sv
// Directed bench for ip_msx_bus_bridge: write, read, immediate ack, timeout, wait and reset mid-access.
module tb_ip_msx_bus_bridge;

  logic       clk = 1'b0;
  logic       n_reset, n_ce, n_rd, n_wr, ack;
  logic [1:0] a;
  logic [7:0] d_in, rdata;
  logic [7:0] d_out, wdata;
  logic       is_output, wait_o, req, wr, timeout;
  logic [1:0] address;

  int n_cmp = 0;
  int n_bad = 0;
  int n_req = 0, n_req_cyc = 0, n_to = 0, n_wait_bad = 0;
  logic req_q = 1'b0;
  int cyc;

  ip_msx_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_n_reset(n_reset), .i_n_ce(n_ce), .i_n_rd(n_rd), .i_n_wr(n_wr),
    .i_a(a), .i_d_in(d_in), .o_d_out(d_out), .o_is_output(is_output), .o_wait(wait_o),
    .o_req(req), .i_ack(ack), .o_wr(wr), .o_address(address), .o_wdata(wdata),
    .i_rdata(rdata), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  logic exp_wait;
`ifdef MSX_BRIDGE_WAIT_EN
  assign exp_wait = req;
`else
  assign exp_wait = 1'b0;
`endif

  always @(negedge clk) begin
    if (req === 1'b1) begin
      n_req_cyc = n_req_cyc + 1;
      if (req_q !== 1'b1) n_req = n_req + 1;
    end
    req_q = req;
    if (timeout === 1'b1) n_to = n_to + 1;
    if (wait_o !== exp_wait) n_wait_bad = n_wait_bad + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int c);
    c = 0;
    while (req !== 1'b1 && c < 10) begin
      step();
      c++;
    end
  endtask

  task automatic clear_counts();
    n_req = 0; n_req_cyc = 0; n_to = 0;
  endtask

  initial begin
    n_reset = 1'b0; n_ce = 1'b1; n_rd = 1'b1; n_wr = 1'b1; ack = 1'b0;
    a = 2'd0; d_in = 8'd0; rdata = 8'd0;
    steps(3);
    chk("rst_req", req, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_dout", d_out, 8'hFF);
    chk("rst_isout", is_output, 0);
    chk("rst_wait", wait_o, 0);
    chk("rst_timeout", timeout, 0);
    n_reset = 1'b1;
    steps(2);

    // Write to port 1, ack on the 5th request cycle
    clear_counts();
    n_ce = 1'b0; a = 2'b01; d_in = 8'h8F; n_wr = 1'b0;
    wait_req(cyc);
    chk("wr_latency_ok", (cyc >= 3 && cyc <= 4), 1);
    chk("wr_wr", wr, 1);
    chk("wr_addr", address, 2'b01);
    chk("wr_wdata", wdata, 8'h8F);
    chk("wr_isout", is_output, 0);
    d_in = 8'h00; a = 2'b10;
    steps(4);
    chk("wr_hold_req", req, 1);
    chk("wr_hold_wdata", wdata, 8'h8F);
    chk("wr_hold_addr", address, 2'b01);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("wr_req_drop", req, 0);
    chk("wr_req_cycles", n_req_cyc, 5);
    n_wr = 1'b1; n_ce = 1'b1;
    steps(4);
    chk("wr_one_req", n_req, 1);
    chk("wr_isout_end", is_output, 0);

    // Timeout on a read: no ack, 16 request cycles
    clear_counts();
    n_ce = 1'b0; a = 2'b11; n_rd = 1'b0;
    wait_req(cyc);
    chk("to_req_seen", req, 1);
    chk("to_isout", is_output, 1);
    steps(15);
    chk("to_req_still", req, 1);
    chk("to_not_yet", timeout, 0);
    step();
    chk("to_pulse", timeout, 1);
    chk("to_req_drop", req, 0);
    chk("to_dout", d_out, 8'hFF);
    step();
    chk("to_pulse_end", timeout, 0);
    chk("to_req_cycles", n_req_cyc, 16);
    chk("to_pulse_count", n_to, 1);
    n_rd = 1'b1; n_ce = 1'b1;
    steps(4);

    // Read from port 0 returning 8'h5A
    clear_counts();
    n_ce = 1'b0; a = 2'b00; n_rd = 1'b0; rdata = 8'h5A;
    wait_req(cyc);
    chk("rd_latency_ok", (cyc >= 3 && cyc <= 4), 1);
    chk("rd_wr", wr, 0);
    chk("rd_addr", address, 2'b00);
    chk("rd_isout", is_output, 1);
    ack = 1'b1;
    step();
    ack = 1'b0; rdata = 8'h00;
    chk("rd_req_drop", req, 0);
    chk("rd_dout", d_out, 8'h5A);
    steps(5);
    chk("rd_isout_hold", is_output, 1);
    n_rd = 1'b1; n_ce = 1'b1;
    steps(2);
    chk("rd_isout_2cyc", is_output, 1);
    step();
    chk("rd_isout_off", is_output, 0);
    chk("rd_one_req", n_req, 1);
    steps(2);

    // Write with ack in the first request cycle, strobe held 1000 cycles
    clear_counts();
    n_ce = 1'b0; a = 2'b10; d_in = 8'h3C; n_wr = 1'b0;
    wait_req(cyc);
    chk("imm_req_seen", req, 1);
    chk("imm_wdata", wdata, 8'h3C);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("imm_req_drop", req, 0);
    steps(1000);
    chk("imm_req_cycles", n_req_cyc, 1);
    chk("imm_one_req", n_req, 1);
    chk("imm_dout_kept", d_out, 8'h5A);
    n_wr = 1'b1; n_ce = 1'b1;
    steps(4);

    // Reset during ST_REQ of a read, then a late ack
    clear_counts();
    n_ce = 1'b0; a = 2'b01; n_rd = 1'b0; rdata = 8'h77;
    wait_req(cyc);
    chk("rmid_req_seen", req, 1);
    chk("rmid_isout", is_output, 1);
    n_reset = 1'b0;
    step();
    chk("rmid_req", req, 0);
    chk("rmid_isout_off", is_output, 0);
    chk("rmid_dout", d_out, 8'hFF);
    n_rd = 1'b1; n_ce = 1'b1;
    steps(3);
    n_reset = 1'b1;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    steps(2);
    chk("rmid_late_ack_req", req, 0);
    chk("rmid_late_ack_dout", d_out, 8'hFF);
    chk("rmid_req_count", n_req, 1);

    chk("wait_track", n_wait_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
